// File: rtl/mux_operand_loader.sv
// Operand loader for a 2:1 mux: edge-detected loads of X/Y, a select S with manual and
// periodic toggling. Optional SWAP input is enabled with macro MUX_LOADER_SWAP_EN.
module mux_operand_loader #(
  parameter int unsigned DIV = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] D,
  input  logic       LD_X,
  input  logic       LD_Y,
  input  logic       TOG,
  input  logic       AUTO,
`ifdef MUX_LOADER_SWAP_EN
  input  logic       SWAP,
`endif
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       S,
  output logic       VALID
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  typedef enum logic [1:0] {StEmpty, StHaveX, StHaveY, StReady} state_e;

  state_e          state_q, state_d;
  logic [3:0]      x_q, x_d, y_q, y_d;
  logic            s_q, s_d;
  logic            valid_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ld_x_q, ld_y_q, tog_q;
  logic            ev_x, ev_y, ev_tog;
  logic            run, wrap;

  assign ev_x   = LD_X & ~ld_x_q;
  assign ev_y   = LD_Y & ~ld_y_q;
  assign ev_tog = TOG & ~tog_q;

`ifdef MUX_LOADER_SWAP_EN
  logic swap_q;
  logic ev_swap;
  assign ev_swap = SWAP & ~swap_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: begin
        if (ev_x && ev_y) state_d = StReady;
        else if (ev_x)    state_d = StHaveX;
        else if (ev_y)    state_d = StHaveY;
      end
      StHaveX: if (ev_y) state_d = StReady;
      StHaveY: if (ev_x) state_d = StReady;
      StReady: state_d = StReady;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (ev_x) x_d = D;
    if (ev_y) y_d = D;
`ifdef MUX_LOADER_SWAP_EN
    // A load in the same cycle wins; the swap is dropped.
    if (ev_swap && (state_q == StReady) && !ev_x && !ev_y) begin
      x_d = y_q;
      y_d = x_q;
    end
`endif
  end

  // A manual toggle coinciding with a wrap still inverts S only once.
  always_comb begin
    run   = (state_q == StReady) && AUTO;
    wrap  = run && (cnt_q == CntMax);
    s_d   = s_q ^ (ev_tog | wrap);
    cnt_d = (!run || ev_tog || wrap) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StEmpty;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ld_x_q  <= 1'b0;
      ld_y_q  <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      valid_q <= (state_d == StReady);
      cnt_q   <= cnt_d;
      ld_x_q  <= LD_X;
      ld_y_q  <= LD_Y;
      tog_q   <= TOG;
    end
  end

`ifdef MUX_LOADER_SWAP_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) swap_q <= 1'b0;
    else        swap_q <= SWAP;
  end
`endif

  assign X     = x_q;
  assign Y     = y_q;
  assign S     = s_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_mux_operand_loader.sv
// Randomized and directed bench for mux_operand_loader (DIV=4) against a behavioural model.
module tb_mux_operand_loader;

  localparam int unsigned Div = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] D = '0;
  logic       LD_X = 1'b0, LD_Y = 1'b0, TOG = 1'b0, AUTO = 1'b0, SWAP = 1'b0;
  logic [3:0] X, Y;
  logic       S, VALID;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: which operands have been loaded, and cycles since the last S change.
  logic [3:0] m_x = '0, m_y = '0;
  logic       m_s = 1'b0;
  bit         m_have_x = 0, m_have_y = 0;
  int         m_run_len = 0;
  logic       p_x = 0, p_y = 0, p_t = 0, p_s = 0;

  mux_operand_loader #(.DIV(Div)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (D),
    .LD_X  (LD_X),
    .LD_Y  (LD_Y),
    .TOG   (TOG),
    .AUTO  (AUTO),
`ifdef MUX_LOADER_SWAP_EN
    .SWAP  (SWAP),
`endif
    .X     (X),
    .Y     (Y),
    .S     (S),
    .VALID (VALID)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic [3:0] d, input logic lx, input logic ly,
                              input logic tg, input logic au, input logic sw);
    bit ex, ey, et, es, ready, wrap;
    if (!rst) begin
      m_x = '0; m_y = '0; m_s = 0; m_have_x = 0; m_have_y = 0; m_run_len = 0;
      p_x = 0; p_y = 0; p_t = 0; p_s = 0;
      return;
    end
    ex = lx && !p_x;
    ey = ly && !p_y;
    et = tg && !p_t;
    es = sw && !p_s;
    ready = m_have_x && m_have_y;
    // S flips after Div consecutive auto cycles in READY; any manual toggle restarts the period.
    wrap = 0;
    if (ready && au) begin
      m_run_len++;
      if (m_run_len == Div) wrap = 1;
    end else begin
      m_run_len = 0;
    end
    if (et || wrap) begin
      m_s = !m_s;
      m_run_len = 0;
    end
`ifdef MUX_LOADER_SWAP_EN
    if (es && ready && !ex && !ey) begin
      logic [3:0] t;
      t = m_x; m_x = m_y; m_y = t;
    end
`else
    if (es) begin end
`endif
    if (ex) begin m_x = d; m_have_x = 1; end
    if (ey) begin m_y = d; m_have_y = 1; end
    p_x = lx; p_y = ly; p_t = tg; p_s = sw;
  endtask

  task automatic step(input logic rst, input logic [3:0] d, input logic lx, input logic ly,
                      input logic tg, input logic au, input logic sw);
    RST_N = rst; D = d; LD_X = lx; LD_Y = ly; TOG = tg; AUTO = au; SWAP = sw;
    @(posedge CLK);
    model_update(rst, d, lx, ly, tg, au, sw);
    #1;
    check_eq("x", {4'h0, X}, {4'h0, m_x});
    check_eq("y", {4'h0, Y}, {4'h0, m_y});
    check_eq("s", {7'h0, S}, {7'h0, m_s});
    check_eq("valid", {7'h0, VALID}, {7'h0, logic'(m_have_x && m_have_y)});
  endtask

  initial begin
    logic s0;

    // Reset state
    step(0, 4'h0, 0, 0, 0, 0, 0);
    step(0, 4'h0, 0, 0, 0, 0, 0);
    check_eq("rst_outs", {X, Y}, 8'h00);
    check_eq("rst_valid", {7'h0, VALID}, 8'h0);

    // Load X then Y
    step(1, 4'hA, 1, 0, 0, 0, 0);
    check_eq("have_x_valid", {7'h0, VALID}, 8'h0);
    step(1, 4'hA, 0, 0, 0, 0, 0);
    step(1, 4'h5, 0, 1, 0, 0, 0);
    check_eq("load_xy", {X, Y}, 8'hA5);
    check_eq("load_valid", {7'h0, VALID}, 8'h1);
    check_eq("load_s", {7'h0, S}, 8'h0);
    step(1, 4'h5, 0, 0, 0, 0, 0);

    // Held strobe produces a single event
    for (int i = 0; i < 10; i++) step(1, (i < 1) ? 4'h3 : 4'h7, 1, 0, 0, 0, 0);
    check_eq("held_ldx", {4'h0, X}, 8'h03);
    step(1, 4'h7, 0, 0, 0, 0, 0);

    // Periodic toggling, then hold with AUTO low
    s0 = m_s;
    for (int k = 1; k <= 16; k++) begin
      step(1, 4'h0, 0, 0, 0, 1, 0);
      check_eq("auto_s", {7'h0, S}, {7'h0, logic'(s0 ^ ((k / 4) % 2 == 1))});
    end
    for (int k = 0; k < 3; k++) step(1, 4'h0, 0, 0, 0, 0, 0);
    check_eq("auto_off_hold", {7'h0, S}, {7'h0, s0});

    // Manual toggle on the wrap cycle inverts once; next wrap four cycles later
    for (int k = 1; k <= 3; k++) step(1, 4'h0, 0, 0, 0, 1, 0);
    step(1, 4'h0, 0, 0, 1, 1, 0);
    check_eq("tog_on_wrap", {7'h0, S}, {7'h0, ~s0});
    for (int k = 1; k <= 3; k++) step(1, 4'h0, 0, 0, 0, 1, 0);
    check_eq("after_wrap_hold", {7'h0, S}, {7'h0, ~s0});
    step(1, 4'h0, 0, 0, 0, 1, 0);
    check_eq("next_wrap", {7'h0, S}, {7'h0, s0});

    // Simultaneous load from EMPTY, then one-cycle reset
    step(0, 4'h0, 0, 0, 0, 0, 0);
    step(1, 4'hC, 1, 1, 0, 0, 0);
    check_eq("both_xy", {X, Y}, 8'hCC);
    check_eq("both_valid", {7'h0, VALID}, 8'h1);
    step(0, 4'hC, 0, 0, 0, 0, 0);
    check_eq("rst2_outs", {X, Y, 1'b0, S, 1'b0, VALID}, {8'h00, 4'h0});

    // Strobe held through reset release loads once after release
    step(0, 4'h6, 1, 0, 0, 0, 0);
    step(1, 4'h6, 1, 0, 0, 0, 0);
    check_eq("rel_load", {4'h0, X}, 8'h06);
    step(1, 4'h9, 1, 0, 0, 0, 0);
    check_eq("rel_single", {4'h0, X}, 8'h06);

`ifdef MUX_LOADER_SWAP_EN
    step(0, 4'h0, 0, 0, 0, 0, 0);
    step(1, 4'h2, 1, 0, 0, 0, 0);
    step(1, 4'h9, 0, 1, 0, 0, 0);
    step(1, 4'h0, 0, 0, 0, 0, 1);
    check_eq("swap_ready", {X, Y}, 8'h92);
    step(0, 4'h0, 0, 0, 0, 0, 0);
    step(1, 4'h2, 1, 0, 0, 0, 0);
    step(1, 4'h0, 0, 0, 0, 0, 1);
    check_eq("swap_have_x", {X, Y}, 8'h20);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 40) != 0), 4'($urandom),
           logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 7) != 0),
           logic'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
